fdiv_mantissa_seq: RTL and testbench

//   Sequential radix-2 restoring divider for normalized FP32 mantissas. It is the

---
 rtl/fdiv_pkg.sv | 17 +
 rtl/fdiv_restore_step.sv | 24 ++
 rtl/fdiv_mantissa_seq.sv | 114 +++++++++++
 tb/tb_fdiv_mantissa_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared constants and the FSM state type for the FP32 mantissa divider.
package fdiv_pkg;

    // Mantissa width with the hidden bit included.
    localparam int FDIV_DW = 24;
    // Quotient width: 1 integer bit, 23 fraction bits, guard and round.
    localparam int FDIV_QW = 26;
    // Iteration counter width.
    localparam int FDIV_CW = $clog2(FDIV_QW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fdiv_state_t;

endpackage

// File: rtl/fdiv_restore_step.sv
// One restoring-division step: compare the partial remainder against the
// divisor and subtract when it fits. Purely combinational.
module fdiv_restore_step
    import fdiv_pkg::*;
#(
    parameter int DW = FDIV_DW
) (
    input  logic [DW:0]   r,
    input  logic [DW-1:0] b,
    output logic          q_bit,
    output logic [DW:0]   r_next
);

    logic [DW:0] b_ext;

    assign b_ext = {1'b0, b};

    // The compare is one bit wider than the mantissa because r < 2b.
    always_comb begin
        q_bit  = (r >= b_ext);
        r_next = q_bit ? (r - b_ext) : r;
    end

endmodule

// File: rtl/fdiv_mantissa_seq.sv
// Sequential radix-2 restoring divider for normalized FP32 mantissas.
// Produces q = floor(a*2^25/b) and the matching remainder, one quotient bit
// per clock, behind a start/busy/done handshake.
// Optional build macro: FDIV_EARLY_TERM_EN -- finish as soon as the partial
// remainder becomes zero (results are identical, only latency changes).
module fdiv_mantissa_seq
    import fdiv_pkg::*;
#(
    parameter int DW = FDIV_DW,
    parameter int QW = FDIV_QW
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] q,
    output logic [DW-1:0] rem
);

    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] CNT_FIRST = CW'(QW - 1);

    fdiv_state_t   state_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [QW-1:0] q_reg;
    logic [DW:0]   r_reg;
    logic [DW-1:0] b_reg;
    logic [CW-1:0] cnt_reg;

    logic          q_bit;
    logic [DW:0]   r_diff;
    logic          last_iter;
    logic          b_zero;
    logic          early_stop;

    fdiv_restore_step #(
        .DW (DW)
    ) u_step (
        .r      (r_reg),
        .b      (b_reg),
        .q_bit  (q_bit),
        .r_next (r_diff)
    );

    assign last_iter = (cnt_reg == '0);
    assign b_zero    = (b_reg == '0);

`ifdef FDIV_EARLY_TERM_EN
    // A zero remainder means every remaining quotient bit is zero.
    assign early_stop = (r_diff == '0);
`else
    assign early_stop = 1'b0;
`endif

    // Control FSM, iteration counter and datapath registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            q_reg     <= '0;
            r_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        b_reg     <= b;
                        r_reg     <= {1'b0, a};
                        q_reg     <= '0;
                        cnt_reg   <= CNT_FIRST;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_CALC;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    q_reg[cnt_reg] <= q_bit;
                    // A zero divisor keeps the dividend unshifted so the
                    // remainder reports a instead of shifting out to zero.
                    if (last_iter || b_zero) begin
                        r_reg <= r_diff;
                    end else begin
                        r_reg <= {r_diff[DW-1:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg - CW'(1);
                    if (last_iter || early_stop) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign q    = q_reg;
    // After the final step the remainder is below b, so the top bit is zero.
    assign rem  = r_reg[DW-1:0];

endmodule

// File: tb/tb_fdiv_mantissa_seq.sv
// Self-checking bench for fdiv_mantissa_seq: directed cases, randomized
// operands against an arithmetic reference, handshake and reset scenarios.
module tb_fdiv_mantissa_seq;
    import fdiv_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [23:0] a;
    logic [23:0] b;
    logic        busy;
    logic        done;
    logic [25:0] q;
    logic [23:0] rem;

    int checks = 0;
    int errors = 0;

    fdiv_mantissa_seq dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .rem   (rem)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division of a*2^25 by b.
    function automatic logic [25:0] ref_q(input logic [23:0] av, input logic [23:0] bv);
        longint unsigned num;
        if (bv == 24'd0) return '1;
        num = longint'(av) << 25;
        return 26'(num / longint'(bv));
    endfunction

    function automatic logic [23:0] ref_rem(input logic [23:0] av, input logic [23:0] bv);
        longint unsigned num;
        longint unsigned qq;
        if (bv == 24'd0) return av;
        num = longint'(av) << 25;
        qq  = num / longint'(bv);
        return 24'(num - qq * longint'(bv));
    endfunction

    // Clocks from accepted start to done.
    function automatic int ref_lat(input logic [23:0] av, input logic [23:0] bv);
`ifdef FDIV_EARLY_TERM_EN
        longint unsigned part;
        if (bv == 24'd0) return 26;
        for (int k = 1; k <= 26; k++) begin
            part = longint'(av) << (k - 1);
            if ((part % longint'(bv)) == 0) return k;
        end
        return 26;
`else
        if (av == bv) return 26;
        return 26;
`endif
    endfunction

    function automatic logic [23:0] rand_mant();
        return {1'b1, 23'($urandom)};
    endfunction

    // Issue a one-cycle start; scramble the inputs afterwards.
    task automatic launch(input logic [23:0] av, input logic [23:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count negedges until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        clrn  = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== '0 || rem !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%h rem=%h, want all zero", busy, done, q, rem);
        end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [23:0] ta [4] = '{24'h800000, 24'hFFFFFF, 24'h800000, 24'h800000};
        logic [23:0] tb [4] = '{24'h800000, 24'h800000, 24'hC00000, 24'h000000};
        logic [25:0] tq [4] = '{26'h2000000, 26'h3FFFFFC, 26'h1555555, 26'h3FFFFFF};
        logic [23:0] tr [4] = '{24'h000000, 24'h000000, 24'h400000, 24'h800000};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_busy: busy=%b, want 1", i, busy);
            end
            wait_done(cyc);
            $display("directed a=%h b=%h q=%h rem=%h lat=%0d", ta[i], tb[i], q, rem, cyc);
            checks++;
            if (cyc != ref_lat(ta[i], tb[i])) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d, want %0d", i, cyc, ref_lat(ta[i], tb[i]));
            end
            checks++;
            if (q !== tq[i] || rem !== tr[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_result: q=%h rem=%h busy=%b, want q=%h rem=%h busy=0", i, q, rem, busy, tq[i], tr[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_done_pulse: done=%b one cycle later, want 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] av;
        logic [23:0] bv;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            av = rand_mant();
            bv = (i % 8 == 3) ? av : rand_mant();
            if (i % 8 == 5) bv = {1'b1, 23'h0};
            launch(av, bv);
            wait_done(cyc);
            $display("random a=%h b=%h q=%h rem=%h lat=%0d", av, bv, q, rem, cyc);
            checks++;
            if (cyc != ref_lat(av, bv) || q !== ref_q(av, bv) || rem !== ref_rem(av, bv)) begin
                errors++;
                $display("FAIL rand%0d: q=%h rem=%h lat=%0d, want q=%h rem=%h lat=%0d",
                         i, q, rem, cyc, ref_q(av, bv), ref_rem(av, bv), ref_lat(av, bv));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        launch(24'h800000, 24'hC00000);
        repeat (4) @(negedge clk);
        a     = 24'hFFFFFF;
        b     = 24'h800000;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        cyc = cyc + 7;
        $display("busy_start a=800000 b=c00000 q=%h rem=%h lat=%0d", q, rem, cyc);
        checks++;
        if (cyc != ref_lat(24'h800000, 24'hC00000) || q !== 26'h1555555 || rem !== 24'h400000) begin
            errors++;
            $display("FAIL start_while_busy: q=%h rem=%h lat=%0d, want q=1555555 rem=400000 lat=%0d",
                     q, rem, cyc, ref_lat(24'h800000, 24'hC00000));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [23:0] a1, b1, a2, b2;
        int cyc;
        a1 = rand_mant();
        b1 = rand_mant();
        a2 = rand_mant();
        b2 = rand_mant();
        launch(a1, b1);
        wait_done(cyc);
        checks++;
        if (q !== ref_q(a1, b1) || rem !== ref_rem(a1, b1)) begin
            errors++;
            $display("FAIL b2b_first: q=%h rem=%h, want q=%h rem=%h", q, rem, ref_q(a1, b1), ref_rem(a1, b1));
        end
        a     = a2;
        b     = b2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(cyc);
        $display("back_to_back a=%h b=%h q=%h rem=%h lat=%0d", a2, b2, q, rem, cyc);
        checks++;
        if (cyc != ref_lat(a2, b2) || q !== ref_q(a2, b2) || rem !== ref_rem(a2, b2)) begin
            errors++;
            $display("FAIL b2b_second: q=%h rem=%h lat=%0d, want q=%h rem=%h lat=%0d",
                     q, rem, cyc, ref_q(a2, b2), ref_rem(a2, b2), ref_lat(a2, b2));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        int seen;
        launch(24'hFFFFFF, 24'h800000);
        repeat (9) @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== '0 || rem !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b q=%h rem=%h, want all zero", busy, done, q, rem);
        end
        @(negedge clk);
        clrn = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_result: busy/done seen %0d cycles, want 0", seen);
        end
        launch(24'hA5A5A5, 24'hC3C3C3);
        wait_done(cyc);
        $display("after_reset a=a5a5a5 b=c3c3c3 q=%h rem=%h lat=%0d", q, rem, cyc);
        checks++;
        if (cyc != ref_lat(24'hA5A5A5, 24'hC3C3C3) || q !== ref_q(24'hA5A5A5, 24'hC3C3C3)
            || rem !== ref_rem(24'hA5A5A5, 24'hC3C3C3)) begin
            errors++;
            $display("FAIL after_reset_op: q=%h rem=%h lat=%0d, want q=%h rem=%h lat=%0d",
                     q, rem, cyc, ref_q(24'hA5A5A5, 24'hC3C3C3), ref_rem(24'hA5A5A5, 24'hC3C3C3),
                     ref_lat(24'hA5A5A5, 24'hC3C3C3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
